// File: rtl/bp_fe_lce_resp_arb.sv
// I-cache LCE response arbiter: merges the miss-request and command response
// streams into one registered ready/valid output. Optional counters: BP_FE_LCE_RESP_ARB_STATS_EN.
module bp_fe_lce_resp_arb
  #(parameter int unsigned resp_width_p   = 128
   ,parameter int unsigned starve_limit_p = 4
   )
  (input  logic                    clk_i
  ,input  logic                    reset_i

  ,input  logic [resp_width_p-1:0] req_resp_i
  ,input  logic                    req_resp_v_i
  ,output logic                    req_resp_yumi_o

  ,input  logic [resp_width_p-1:0] cmd_resp_i
  ,input  logic                    cmd_resp_v_i
  ,output logic                    cmd_resp_yumi_o

  ,output logic [resp_width_p-1:0] lce_resp_o
  ,output logic                    lce_resp_v_o
  ,input  logic                    lce_resp_ready_i
`ifdef BP_FE_LCE_RESP_ARB_STATS_EN
  ,output logic [31:0]             req_grant_cnt_o
  ,output logic [31:0]             cmd_grant_cnt_o
  ,output logic [31:0]             stall_cnt_o
`endif
  );

  localparam int unsigned starve_cnt_width_lp = $clog2(starve_limit_p + 1);
  localparam logic [starve_cnt_width_lp-1:0] starve_max_lp = starve_cnt_width_lp'(starve_limit_p);

  logic                           v_q, v_d;
  logic [resp_width_p-1:0]        data_q, data_d;
  logic [starve_cnt_width_lp-1:0] starve_cnt_q, starve_cnt_d;

  logic slot_free;
  logic grant_req;
  logic grant_cmd;

  // Fixed priority to the request side unless the command side has starved
  always_comb begin
    slot_free = ~v_q | lce_resp_ready_i;
    grant_req = 1'b0;
    grant_cmd = 1'b0;
    if (~reset_i & slot_free) begin
      if (cmd_resp_v_i & (~req_resp_v_i | (starve_cnt_q == starve_max_lp)))
        grant_cmd = 1'b1;
      else if (req_resp_v_i)
        grant_req = 1'b1;
    end
  end

  assign req_resp_yumi_o = grant_req;
  assign cmd_resp_yumi_o = grant_cmd;

  always_comb begin
    v_d          = v_q;
    data_d       = data_q;
    starve_cnt_d = starve_cnt_q;

    // Drain and reload share a cycle, so a free slot always takes the winner
    if (slot_free) begin
      v_d = grant_req | grant_cmd;
      if (grant_cmd)
        data_d = cmd_resp_i;
      else if (grant_req)
        data_d = req_resp_i;
    end

    if (~cmd_resp_v_i)
      starve_cnt_d = '0;
    else if (slot_free) begin
      if (grant_cmd)
        starve_cnt_d = '0;
      else if (starve_cnt_q != starve_max_lp)
        starve_cnt_d = starve_cnt_q + starve_cnt_width_lp'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v_q          <= 1'b0;
      data_q       <= '0;
      starve_cnt_q <= '0;
    end else begin
      v_q          <= v_d;
      data_q       <= data_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign lce_resp_o   = data_q;
  assign lce_resp_v_o = v_q;

`ifdef BP_FE_LCE_RESP_ARB_STATS_EN
  logic [31:0] req_grant_cnt_q, req_grant_cnt_d;
  logic [31:0] cmd_grant_cnt_q, cmd_grant_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Free-running event counters, wrapping at 2^32
  always_comb begin
    req_grant_cnt_d = req_grant_cnt_q + 32'(grant_req);
    cmd_grant_cnt_d = cmd_grant_cnt_q + 32'(grant_cmd);
    stall_cnt_d     = stall_cnt_q + 32'(v_q & ~lce_resp_ready_i);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      req_grant_cnt_q <= '0;
      cmd_grant_cnt_q <= '0;
      stall_cnt_q     <= '0;
    end else begin
      req_grant_cnt_q <= req_grant_cnt_d;
      cmd_grant_cnt_q <= cmd_grant_cnt_d;
      stall_cnt_q     <= stall_cnt_d;
    end
  end

  assign req_grant_cnt_o = req_grant_cnt_q;
  assign cmd_grant_cnt_o = cmd_grant_cnt_q;
  assign stall_cnt_o     = stall_cnt_q;
`endif

endmodule

// File: tb/tb_bp_fe_lce_resp_arb.sv
// Bench for bp_fe_lce_resp_arb: directed vector table plus random traffic vs. a reference model.
module tb_bp_fe_lce_resp_arb;

  localparam int unsigned RW    = 128;
  localparam int unsigned LIMIT = 4;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic [RW-1:0] req_resp_i = '0;
  logic          req_resp_v_i = 1'b0;
  logic          req_resp_yumi_o;
  logic [RW-1:0] cmd_resp_i = '0;
  logic          cmd_resp_v_i = 1'b0;
  logic          cmd_resp_yumi_o;
  logic [RW-1:0] lce_resp_o;
  logic          lce_resp_v_o;
  logic          lce_resp_ready_i = 1'b0;
`ifdef BP_FE_LCE_RESP_ARB_STATS_EN
  logic [31:0]   req_grant_cnt_o, cmd_grant_cnt_o, stall_cnt_o;
`endif

  bp_fe_lce_resp_arb #(.resp_width_p(RW), .starve_limit_p(LIMIT)) dut
    (.clk_i(clk_i), .reset_i(reset_i)
    ,.req_resp_i(req_resp_i), .req_resp_v_i(req_resp_v_i), .req_resp_yumi_o(req_resp_yumi_o)
    ,.cmd_resp_i(cmd_resp_i), .cmd_resp_v_i(cmd_resp_v_i), .cmd_resp_yumi_o(cmd_resp_yumi_o)
    ,.lce_resp_o(lce_resp_o), .lce_resp_v_o(lce_resp_v_o), .lce_resp_ready_i(lce_resp_ready_i)
`ifdef BP_FE_LCE_RESP_ARB_STATS_EN
    ,.req_grant_cnt_o(req_grant_cnt_o), .cmd_grant_cnt_o(cmd_grant_cnt_o), .stall_cnt_o(stall_cnt_o)
`endif
    );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  logic s_ry, s_cy;

  typedef struct {
    logic       rv; logic [7:0] rd;
    logic       cv; logic [7:0] cd;
    logic       rdy; logic      rst;
    logic       ery; logic      ecy;
    logic       ev;  logic [7:0] ed;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic rv, input logic [7:0] rd, input logic cv, input logic [7:0] cd,
                              input logic rdy, input logic rst, input logic ery, input logic ecy,
                              input logic ev, input logic [7:0] ed);
    vec_t v;
    v = '{rv, rd, cv, cd, rdy, rst, ery, ecy, ev, ed};
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive at negedge, sample yumis just after, then sample registered outputs after posedge
  task automatic tick(input logic rv, input logic [RW-1:0] rd, input logic cv, input logic [RW-1:0] cd,
                      input logic rdy, input logic rst);
    @(negedge clk_i);
    req_resp_v_i = rv; req_resp_i = rd;
    cmd_resp_v_i = cv; cmd_resp_i = cd;
    lce_resp_ready_i = rdy; reset_i = rst;
    #1;
    s_ry = req_resp_yumi_o;
    s_cy = cmd_resp_yumi_o;
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = tbl[i];
    tick(v.rv, RW'(v.rd), v.cv, RW'(v.cd), v.rdy, v.rst);
    chk($sformatf("req_yumi[%0d]", i), RW'(s_ry), RW'(v.ery));
    chk($sformatf("cmd_yumi[%0d]", i), RW'(s_cy), RW'(v.ecy));
    chk($sformatf("v_o[%0d]", i), RW'(lce_resp_v_o), RW'(v.ev));
    if (v.ev || v.rst)
      chk($sformatf("data_o[%0d]", i), lce_resp_o, RW'(v.ed));
  endtask

  // Reference model state
  int           mcnt;
  logic         mv;
  logic [RW-1:0] md;
  logic         rp, cp, rdy, rst;
  logic [RW-1:0] rdat, cdat;
  logic         ery, ecy, sf;

  initial begin
    // Part A: reset held with both valid, then the starvation pattern
    for (int i = 0; i < 3; i++) add(1, 8'h11, 1, 8'h21, 1, 1, 0, 0, 0, 8'h00);
    add(1, 8'h01, 1, 8'hC0, 1, 0, 1, 0, 1, 8'h01);
    add(1, 8'h02, 1, 8'hC0, 1, 0, 1, 0, 1, 8'h02);
    add(1, 8'h03, 1, 8'hC0, 1, 0, 1, 0, 1, 8'h03);
    add(1, 8'h04, 1, 8'hC0, 1, 0, 1, 0, 1, 8'h04);
    add(1, 8'h05, 1, 8'hC0, 1, 0, 0, 1, 1, 8'hC0);
    add(1, 8'h05, 1, 8'hC1, 1, 0, 1, 0, 1, 8'h05);
    add(1, 8'h06, 1, 8'hC1, 1, 0, 1, 0, 1, 8'h06);
    add(1, 8'h07, 1, 8'hC1, 1, 0, 1, 0, 1, 8'h07);
    add(1, 8'h08, 1, 8'hC1, 1, 0, 1, 0, 1, 8'h08);
    add(1, 8'h09, 1, 8'hC1, 1, 0, 0, 1, 1, 8'hC1);
    for (int i = 0; i < 13; i++) run_vec(i);
`ifdef BP_FE_LCE_RESP_ARB_STATS_EN
    chk("req_grant_cnt", RW'(req_grant_cnt_o), RW'(8));
    chk("cmd_grant_cnt", RW'(cmd_grant_cnt_o), RW'(2));
    chk("stall_cnt", RW'(stall_cnt_o), RW'(0));
`endif

    // Part B: cmd-only, stall with starve counter at 3, back-to-back, reset mid-transfer
    add(0, 8'h00, 1, 8'hA5, 1, 0, 0, 1, 1, 8'hA5);
    add(1, 8'h31, 1, 8'hB0, 1, 0, 1, 0, 1, 8'h31);
    add(1, 8'h32, 1, 8'hB0, 1, 0, 1, 0, 1, 8'h32);
    add(1, 8'h33, 1, 8'hB0, 1, 0, 1, 0, 1, 8'h33);
    for (int i = 0; i < 5; i++) add(1, 8'h34, 1, 8'hB0, 0, 0, 0, 0, 1, 8'h33);
    add(1, 8'h34, 1, 8'hB0, 1, 0, 1, 0, 1, 8'h34);
    add(1, 8'h35, 1, 8'hB0, 1, 0, 0, 1, 1, 8'hB0);
    add(1, 8'h01, 0, 8'h00, 1, 0, 1, 0, 1, 8'h01);
    add(1, 8'h02, 0, 8'h00, 1, 0, 1, 0, 1, 8'h02);
    add(1, 8'h03, 0, 8'h00, 1, 0, 1, 0, 1, 8'h03);
    add(0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00);
    add(1, 8'h44, 0, 8'h00, 0, 0, 1, 0, 1, 8'h44);
    add(1, 8'h45, 0, 8'h00, 0, 0, 0, 0, 1, 8'h44);
    add(1, 8'h45, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00);
    add(1, 8'h45, 0, 8'h00, 1, 0, 1, 0, 1, 8'h45);
    for (int i = 13; i < tbl.size(); i++) begin
      run_vec(i);
`ifdef BP_FE_LCE_RESP_ARB_STATS_EN
      if (i == 22) chk("stall_cnt_after_stall", RW'(stall_cnt_o), RW'(5));
`endif
    end

    // Part C: random traffic against the reference model
    tick(0, '0, 0, '0, 1, 1);
    tick(0, '0, 0, '0, 1, 1);
    mv = 1'b0; md = '0; mcnt = 0; rp = 1'b0; cp = 1'b0; rdat = '0; cdat = '0;
    for (int n = 0; n < 2000; n++) begin
      if (!rp && $urandom_range(0, 9) < 7) begin
        rp = 1'b1; rdat = {$urandom, $urandom, $urandom, $urandom};
      end
      if (!cp && $urandom_range(0, 9) < 5) begin
        cp = 1'b1; cdat = {$urandom, $urandom, $urandom, $urandom};
      end
      rdy = ($urandom_range(0, 9) < 7);
      rst = ($urandom_range(0, 99) == 0);

      ery = 1'b0; ecy = 1'b0;
      if (rst) begin
        mv = 1'b0; md = '0; mcnt = 0;
      end else begin
        sf = !mv || rdy;
        if (sf) begin
          if (rp && cp) ecy = (mcnt == LIMIT);
          else          ecy = cp;
          ery = rp && !ecy;
        end
        if (!cp)        mcnt = 0;
        else if (!sf)   mcnt = mcnt;
        else if (ecy)   mcnt = 0;
        else            mcnt = (mcnt + 1 > LIMIT) ? LIMIT : mcnt + 1;
        if (sf) begin
          mv = ery || ecy;
          if (ecy)      md = cdat;
          else if (ery) md = rdat;
        end
      end

      tick(rp, rdat, cp, cdat, rdy, rst);
      chk("rnd_req_yumi", RW'(s_ry), RW'(ery));
      chk("rnd_cmd_yumi", RW'(s_cy), RW'(ecy));
      chk("rnd_v_o", RW'(lce_resp_v_o), RW'(mv));
      if (mv || rst) chk("rnd_data_o", lce_resp_o, md);
      if (ery) rp = 1'b0;
      if (ecy) cp = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
